// File: rtl/toy_bus_pkg.sv
// Shared ToyBus definitions: FSM state encoding, opcodes, field widths and the
// read-timeout error pattern.
package toy_bus_pkg;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam logic [DATA_W-1:0] TIMEOUT_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RSP      = 2'd3
  } state_t;

endpackage

// File: rtl/toy_bus_mem_initiator.sv
// Single-outstanding CPU-to-ToyBus memory initiator (posted writes, acked reads).
// Optional read watchdog enabled by defining TOY_BUS_INITIATOR_TIMEOUT_EN.
module toy_bus_mem_initiator
  import toy_bus_pkg::*;
#(
  parameter logic [3:0] NODE_ID     = 4'd1,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cpu_req_vld,
  output logic        cpu_req_rdy,
  input  logic [31:0] cpu_req_addr,
  input  logic        cpu_req_wr,
  input  logic [31:0] cpu_req_wdata,
  input  logic [3:0]  cpu_req_strb,

  output logic        cpu_rsp_vld,
  input  logic        cpu_rsp_rdy,
  output logic [31:0] cpu_rsp_rdata,
  output logic        cpu_rsp_err,

  output logic        out0_req_vld,
  input  logic        out0_req_rdy,
  output logic [31:0] out0_req_addr,
  output logic [3:0]  out0_req_strb,
  output logic [31:0] out0_req_data,
  output logic        out0_req_opcode,
  output logic [3:0]  out0_req_src_id,
  output logic [3:0]  out0_req_tgt_id,

  input  logic        out0_ack_vld,
  output logic        out0_ack_rdy,
  input  logic        out0_ack_opcode,
  input  logic [31:0] out0_ack_data,
  input  logic [3:0]  out0_ack_src_id,
  input  logic [3:0]  out0_ack_tgt_id
);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  strb_q;
  logic        wr_q;

  logic accept;
  logic req_fire;
  logic ack_match;
  logic timeout;

  assign accept    = cpu_req_vld & (state_q == ST_IDLE);
  assign req_fire  = out0_req_rdy & (state_q == ST_REQ);
  assign ack_match = out0_ack_vld & (state_q == ST_WAIT_ACK)
                   & (out0_ack_tgt_id == NODE_ID) & (out0_ack_opcode == OP_RD);

`ifdef TOY_BUS_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  // The count sits at TIMEOUT_CYC-1 during the last allowed WAIT_ACK cycle.
  assign timeout = (state_q == ST_WAIT_ACK) & (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (req_fire) begin
        wait_cnt_q <= '0;
      end else if (state_q == ST_WAIT_ACK) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if ((req_fire && wr_q) || ack_match) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cpu_rsp_err = err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign timeout     = 1'b0;
  assign cpu_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cpu_req_rdy  = 1'b0;
    out0_req_vld = 1'b0;
    out0_ack_rdy = 1'b0;
    cpu_rsp_vld  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cpu_req_rdy = 1'b1;
        if (cpu_req_vld) state_d = ST_REQ;
      end
      ST_REQ: begin
        out0_req_vld = 1'b1;
        if (out0_req_rdy) state_d = wr_q ? ST_RSP : ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        out0_ack_rdy = 1'b1;
        if (ack_match || timeout) state_d = ST_RSP;
      end
      ST_RSP: begin
        cpu_rsp_vld = 1'b1;
        if (cpu_rsp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields and response data are only loaded at handshakes, so they
  // stay stable under backpressure on either side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cpu_req_addr;
        wdata_q <= cpu_req_wdata;
        strb_q  <= cpu_req_wr ? cpu_req_strb : 4'b0;
        wr_q    <= cpu_req_wr;
      end
      if (req_fire && wr_q) begin
        rdata_q <= '0;
      end else if (ack_match) begin
        rdata_q <= out0_ack_data;
      end else if (timeout) begin
        rdata_q <= TIMEOUT_ERR_DATA;
      end
    end
  end

  assign out0_req_addr   = addr_q;
  assign out0_req_data   = wdata_q;
  assign out0_req_strb   = strb_q;
  assign out0_req_opcode = wr_q;
  assign out0_req_src_id = NODE_ID;
  assign out0_req_tgt_id = addr_q[31:28];
  assign cpu_rsp_rdata   = rdata_q;

  logic unused_ack_src;
  assign unused_ack_src = ^out0_ack_src_id;

endmodule

// File: tb/tb_toy_bus_mem_initiator.sv
// Self-checking bench for toy_bus_mem_initiator: directed scenarios plus random
// transactions checked against a transaction-level expectation model.
module tb_toy_bus_mem_initiator;

  localparam logic [3:0] NID  = 4'd1;
  localparam int         TCYC = 8;

  logic        clk;
  logic        rst_n;
  logic        cpu_req_vld;
  logic        cpu_req_rdy;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_wr;
  logic [31:0] cpu_req_wdata;
  logic [3:0]  cpu_req_strb;
  logic        cpu_rsp_vld;
  logic        cpu_rsp_rdy;
  logic [31:0] cpu_rsp_rdata;
  logic        cpu_rsp_err;
  logic        out0_req_vld;
  logic        out0_req_rdy;
  logic [31:0] out0_req_addr;
  logic [3:0]  out0_req_strb;
  logic [31:0] out0_req_data;
  logic        out0_req_opcode;
  logic [3:0]  out0_req_src_id;
  logic [3:0]  out0_req_tgt_id;
  logic        out0_ack_vld;
  logic        out0_ack_rdy;
  logic        out0_ack_opcode;
  logic [31:0] out0_ack_data;
  logic [3:0]  out0_ack_src_id;
  logic [3:0]  out0_ack_tgt_id;

  int n_checks;
  int n_fail;
  int step;

  toy_bus_mem_initiator #(.NODE_ID(NID), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_vld(cpu_req_vld), .cpu_req_rdy(cpu_req_rdy), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wr(cpu_req_wr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_strb(cpu_req_strb),
    .cpu_rsp_vld(cpu_rsp_vld), .cpu_rsp_rdy(cpu_rsp_rdy), .cpu_rsp_rdata(cpu_rsp_rdata),
    .cpu_rsp_err(cpu_rsp_err),
    .out0_req_vld(out0_req_vld), .out0_req_rdy(out0_req_rdy), .out0_req_addr(out0_req_addr),
    .out0_req_strb(out0_req_strb), .out0_req_data(out0_req_data),
    .out0_req_opcode(out0_req_opcode), .out0_req_src_id(out0_req_src_id),
    .out0_req_tgt_id(out0_req_tgt_id),
    .out0_ack_vld(out0_ack_vld), .out0_ack_rdy(out0_ack_rdy), .out0_ack_opcode(out0_ack_opcode),
    .out0_ack_data(out0_ack_data), .out0_ack_src_id(out0_ack_src_id),
    .out0_ack_tgt_id(out0_ack_tgt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge clk);
    step++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, 32'(cpu_req_rdy), 32'd1);
    check({tag, "_rsp_vld"}, 32'(cpu_rsp_vld), 32'd0);
    check({tag, "_out_vld"}, 32'(out0_req_vld), 32'd0);
    check({tag, "_ack_rdy"}, 32'(out0_ack_rdy), 32'd0);
    check({tag, "_rdata"}, cpu_rsp_rdata, 32'd0);
    check({tag, "_err"}, 32'(cpu_rsp_err), 32'd0);
    check({tag, "_addr"}, out0_req_addr, 32'd0);
    check({tag, "_data"}, out0_req_data, 32'd0);
    check({tag, "_strb"}, 32'(out0_req_strb), 32'd0);
    check({tag, "_opc"}, 32'(out0_req_opcode), 32'd0);
    check({tag, "_src"}, 32'(out0_req_src_id), 32'(NID));
    check({tag, "_tgt"}, 32'(out0_req_tgt_id), 32'd0);
  endtask

  // Expected request fields derived from the field-mapping rules.
  task automatic check_req(input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    logic [3:0] exp_strb;
    exp_strb = wr ? strb : 4'h0;
    check("req_vld", 32'(out0_req_vld), 32'd1);
    check("req_addr", out0_req_addr, addr);
    check("req_data", out0_req_data, wdata);
    check("req_strb", 32'(out0_req_strb), 32'(exp_strb));
    check("req_opc", 32'(out0_req_opcode), 32'(wr));
    check("req_src", 32'(out0_req_src_id), 32'(NID));
    check("req_tgt", 32'(out0_req_tgt_id), addr >> 28);
    check("req_cpu_rdy", 32'(cpu_req_rdy), 32'd0);
    check("req_ack_rdy", 32'(out0_ack_rdy), 32'd0);
  endtask

  task automatic drive_ack(input logic opc, input logic [3:0] tgt, input logic [31:0] data);
    logic [31:0] r;
    r = $urandom;
    out0_ack_vld    = 1'b1;
    out0_ack_opcode = opc;
    out0_ack_tgt_id = tgt;
    out0_ack_data   = data;
    out0_ack_src_id = r[3:0];
  endtask

  task automatic scramble_cpu_req();
    logic [31:0] r;
    r = $urandom;
    cpu_req_addr  = $urandom;
    cpu_req_wdata = $urandom;
    cpu_req_wr    = r[0];
    cpu_req_strb  = r[7:4];
  endtask

  task automatic finish_rsp(input string tag, input logic [31:0] exp_data, input logic exp_err,
                            input int rsp_stall);
    for (int i = 0; i <= rsp_stall; i++) begin
      check({tag, "_rsp_vld"}, 32'(cpu_rsp_vld), 32'd1);
      check({tag, "_rdata"}, cpu_rsp_rdata, exp_data);
      check({tag, "_err"}, 32'(cpu_rsp_err), 32'(exp_err));
      check({tag, "_busy"}, 32'(cpu_req_rdy), 32'd0);
      check({tag, "_no_ack"}, 32'(out0_ack_rdy), 32'd0);
      if (i == rsp_stall) cpu_rsp_rdy = 1'b1;
      tick();
    end
    cpu_rsp_rdy = 1'b0;
    check({tag, "_rsp_done"}, 32'(cpu_rsp_vld), 32'd0);
    check({tag, "_idle_rdy"}, 32'(cpu_req_rdy), 32'd1);
  endtask

  // Issue a request and complete the ToyBus request handshake.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int req_stall);
    check("accept_rdy", 32'(cpu_req_rdy), 32'd1);
    cpu_req_vld   = 1'b1;
    cpu_req_addr  = addr;
    cpu_req_wr    = wr;
    cpu_req_wdata = wdata;
    cpu_req_strb  = strb;
    tick();
    cpu_req_vld  = 1'b0;
    scramble_cpu_req();
    out0_req_rdy = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      check_req(addr, wr, wdata, strb);
      tick();
    end
    check_req(addr, wr, wdata, strb);
    out0_req_rdy = 1'b1;
    tick();
    out0_req_rdy = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [31:0] addr, input logic wr,
                     input logic [31:0] wdata, input logic [3:0] strb, input int req_stall,
                     input int n_stray, input int ack_gap, input logic [31:0] ack_data,
                     input int rsp_stall);
    int          t0;
    int          exp_lat;
    logic [31:0] exp_data;
    t0 = step;
    issue(addr, wr, wdata, strb, req_stall);
    if (wr) begin
      exp_data = 32'd0;
      exp_lat  = 2 + req_stall;
    end else begin
      exp_data = ack_data;
      exp_lat  = 3 + req_stall + n_stray + ack_gap;
      for (int i = 0; i < n_stray; i++) begin
        check({tag, "_wait_ack_rdy"}, 32'(out0_ack_rdy), 32'd1);
        check({tag, "_wait_no_rsp"}, 32'(cpu_rsp_vld), 32'd0);
        if (i % 2 == 0) drive_ack(1'b0, NID + 4'd1, $urandom);
        else            drive_ack(1'b1, NID, $urandom);
        tick();
      end
      out0_ack_vld = 1'b0;
      for (int i = 0; i < ack_gap; i++) begin
        check({tag, "_gap_ack_rdy"}, 32'(out0_ack_rdy), 32'd1);
        tick();
      end
      check({tag, "_ack_rdy"}, 32'(out0_ack_rdy), 32'd1);
      drive_ack(1'b0, NID, ack_data);
      tick();
      out0_ack_vld = 1'b0;
    end
    check({tag, "_latency"}, 32'(step - t0), 32'(exp_lat));
    finish_rsp(tag, exp_data, 1'b0, rsp_stall);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int          n;
    int          seen;
    n_checks = 0;
    n_fail   = 0;
    step     = 0;
    rst_n = 1'b0;
    cpu_req_vld = 1'b0; cpu_req_addr = '0; cpu_req_wr = 1'b0;
    cpu_req_wdata = '0; cpu_req_strb = '0; cpu_rsp_rdy = 1'b0; out0_req_rdy = 1'b0;
    out0_ack_vld = 1'b0; out0_ack_opcode = 1'b0; out0_ack_data = '0;
    out0_ack_src_id = '0; out0_ack_tgt_id = '0;
    tick(); tick();
    check_reset_outputs("rst_during");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_after");

    // Posted write and basic read.
    txn("wr_basic", 32'h2000_0010, 1'b1, 32'h1234_5678, 4'hF, 0, 0, 0, 32'h0, 0);
    txn("rd_basic", 32'h1000_0004, 1'b0, 32'hAAAA_5555, 4'hA, 0, 0, 0, 32'hCAFE_F00D, 0);

    // Backpressure on both sides.
    txn("wr_bp", 32'h3000_0100, 1'b1, 32'h0BAD_F00D, 4'h5, 5, 0, 0, 32'h0, 4);
    txn("rd_bp", 32'h7000_0200, 1'b0, 32'h1111_2222, 4'hF, 5, 0, 0, 32'h5151_A5A5, 4);

    // Stray acks: wrong target, then write opcode, then the real one.
    txn("rd_stray", 32'h1000_0008, 1'b0, 32'h0, 4'h0, 0, 2, 0, 32'h600D_DA7A, 0);

    // Reset while waiting for an ack; the late ack must be ignored.
    issue(32'h4000_0040, 1'b0, 32'h0, 4'h0, 0);
    check("rst_mid_wait", 32'(out0_ack_rdy), 32'd1);
    rst_n = 1'b0;
    tick(); tick();
    check_reset_outputs("rst_mid");
    rst_n = 1'b1;
    drive_ack(1'b0, NID, 32'hBADD_A7A0);
    check("late_ack_rdy", 32'(out0_ack_rdy), 32'd0);
    tick();
    out0_ack_vld = 1'b0;
    check("late_ack_no_rsp", 32'(cpu_rsp_vld), 32'd0);
    check("late_ack_idle", 32'(cpu_req_rdy), 32'd1);
    txn("rd_after_rst", 32'h4000_0044, 1'b0, 32'h0, 4'h3, 0, 0, 1, 32'h0123_4567, 1);

`ifdef TOY_BUS_INITIATOR_TIMEOUT_EN
    // No ack: response arrives after TCYC WAIT_ACK cycles with the error pattern.
    issue(32'h5000_0000, 1'b0, 32'h0, 4'h0, 0);
    n = 1;
    while (!cpu_rsp_vld && n < 40) begin
      tick();
      if (!cpu_rsp_vld) n++;
    end
    check("to_wait_cycles", 32'(n), 32'(TCYC));
    finish_rsp("to_err", 32'hDEAD_BEEF, 1'b1, 0);
    // Matching ack in the last allowed cycle wins over the timeout.
    issue(32'h5000_0004, 1'b0, 32'h0, 4'h0, 0);
    for (int i = 1; i < TCYC; i++) tick();
    check("to_edge_ack_rdy", 32'(out0_ack_rdy), 32'd1);
    drive_ack(1'b0, NID, 32'h7777_0008);
    tick();
    out0_ack_vld = 1'b0;
    finish_rsp("to_edge", 32'h7777_0008, 1'b0, 0);
`else
    // Without the watchdog the read waits as long as it takes.
    issue(32'h5000_0000, 1'b0, 32'h0, 4'h0, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_rsp_vld || !out0_ack_rdy) seen++;
      tick();
    end
    check("nowd_still_waiting", 32'(seen), 32'd0);
    drive_ack(1'b0, NID, 32'h7777_0040);
    tick();
    out0_ack_vld = 1'b0;
    finish_rsp("nowd", 32'h7777_0040, 1'b0, 0);
`endif

    // Random transactions; stray count kept below the watchdog limit.
    for (int k = 0; k < 30; k++) begin
      r = $urandom;
      a = $urandom;
      txn("rnd", a, r[0], $urandom, r[7:4], int'(r[10:8]) % 4, int'(r[12:11]),
          int'(r[14:13]) % 3, $urandom, int'(r[17:15]) % 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toy_bus_mem_initiator.md
TOY_BUS_MEM_INITIATOR -- requirements
Module: toy_bus_mem_initiator

Interface
REQ-001 SHALL have parameter NODE_ID, default 4'd1, driving out0_req_src_id and the expected out0_ack_tgt_id.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, giving the watchdog limit in cycles (used only under REQ-031).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising edge), rst_n input 1 (asynchronous, active-low).
REQ-004 SHALL have upstream request ports: cpu_req_vld in 1; cpu_req_rdy out 1; cpu_req_addr in 32; cpu_req_wr in 1 (1 = write); cpu_req_wdata in 32; cpu_req_strb in 4.
REQ-005 SHALL have upstream response ports: cpu_rsp_vld out 1; cpu_rsp_rdy in 1; cpu_rsp_rdata out 32; cpu_rsp_err out 1.
REQ-006 SHALL have ToyBus request ports: out0_req_vld out 1; out0_req_rdy in 1; out0_req_addr out 32; out0_req_strb out 4; out0_req_data out 32; out0_req_opcode out 1 (1 = write, 0 = read); out0_req_src_id out 4; out0_req_tgt_id out 4.
REQ-007 SHALL have ToyBus ack ports: out0_ack_vld in 1; out0_ack_rdy out 1; out0_ack_opcode in 1; out0_ack_data in 32; out0_ack_src_id in 4; out0_ack_tgt_id in 4.

Function
REQ-010 SHALL implement a single-outstanding FSM with states IDLE, REQ, WAIT_ACK and RSP.
REQ-011 SHALL assert cpu_req_rdy only in IDLE; a cpu_req_vld & cpu_req_rdy handshake SHALL register addr, wr, wdata and strb and move to REQ.
REQ-012 In REQ, SHALL drive out0_req_vld=1 from registers only, with no combinational path from cpu_req_*; first request valid SHALL appear 1 cycle after acceptance.
REQ-013 Request field mapping SHALL be: out0_req_addr = reg addr; data = reg wdata; strb = reg strb (forced to 4'b0 for reads); opcode = reg wr; src_id = NODE_ID; tgt_id = reg addr[31:28].
REQ-014 SHALL hold all out0_req_* fields stable while out0_req_vld=1 and out0_req_rdy=0.
REQ-015 On REQ handshake, a write SHALL go to RSP with rdata=0 and err=0 (posted write; the target returns no ack for writes).
REQ-016 On REQ handshake, a read SHALL go to WAIT_ACK.
REQ-017 SHALL assert out0_ack_rdy=1 only in WAIT_ACK and 0 in all other states.
REQ-018 In WAIT_ACK, an ack with tgt_id==NODE_ID and opcode==0 SHALL capture out0_ack_data into rdata with err=0 and move to RSP.
REQ-019 In WAIT_ACK, an ack with tgt_id!=NODE_ID or opcode==1 SHALL be consumed and dropped; the state SHALL remain WAIT_ACK.
REQ-020 In RSP, SHALL hold cpu_rsp_vld=1 with stable rdata/err; the cpu_rsp handshake SHALL return to IDLE. There SHALL be no IDLE bypass, so the next request is accepted no earlier than the cycle after the response handshake.
REQ-021 Read latency SHALL be: response valid 1 cycle after the accepted matching ack; minimum request-accept to response-valid = 3 cycles with rdy held high and ack arriving in the cycle after the request handshake.

Reset
REQ-025 Asserting rst_n low at any time, including mid-transaction, SHALL force IDLE and clear all registered fields.
REQ-026 Output values during and after reset SHALL be: cpu_req_rdy=1; cpu_rsp_vld=0; out0_req_vld=0; out0_ack_rdy=0; rdata=0; err=0; all out0_req_* fields=0 except src_id=NODE_ID.
REQ-027 An in-flight transaction at reset SHALL be abandoned, and a late ack SHALL be ignored (out0_ack_rdy=0 in IDLE).

Configuration
REQ-030 Macro TOY_BUS_INITIATOR_TIMEOUT_EN SHALL select the watchdog feature.
REQ-031 With the macro defined, a counter SHALL clear on entry to WAIT_ACK and increment each WAIT_ACK cycle; on reaching TIMEOUT_CYC without a matching ack, the FSM SHALL move to RSP with rdata=32'hDEAD_BEEF and err=1.
REQ-032 A matching ack arriving in the same cycle as the timeout SHALL win, giving err=0.
REQ-033 Without the macro, the counter logic SHALL be absent, WAIT_ACK SHALL persist indefinitely, and cpu_rsp_err SHALL be tied 0.

Structure
REQ-040 The shared package toy_bus_pkg SHALL hold: state enum values, opcode constants (OP_RD=0, OP_WR=1), ID width 4, DATA/ADDR width 32, and the timeout error pattern.
REQ-041 The design SHALL be a flat single module with no sub-module.

Verification
REQ-050 Write: addr 32'h2000_0010, wdata 32'h1234_5678, strb 4'hF, out0_req_rdy=1 -> out0_req opcode=1, tgt_id=4'h2, src_id=NODE_ID one cycle later; cpu_rsp rdata=0, err=0 next cycle; no ack consumed.
REQ-051 Read: addr 32'h1000_0004; ack tgt_id=NODE_ID, data 32'hCAFE_F00D the cycle after the request handshake -> cpu_rsp rdata=32'hCAFE_F00D, err=0, 3 cycles after accept.
REQ-052 Backpressure: out0_req_rdy=0 for 5 cycles, then cpu_rsp_rdy=0 for 4 cycles -> all fields stable throughout; cpu_req_rdy=0 until the response handshake.
REQ-053 Stray acks: in WAIT_ACK, ack tgt_id=NODE_ID+1, then ack opcode=1, then a valid ack -> first two dropped; response carries only the third ack's data.
REQ-054 Reset mid-WAIT_ACK: rst_n low 2 cycles, then a late ack -> out0_ack_rdy=0, no cpu_rsp; next read completes normally.
REQ-055 Timeout (macro on, TIMEOUT_CYC=8): no ack -> cpu_rsp err=1, rdata=32'hDEAD_BEEF after 8 WAIT_ACK cycles; matching ack on cycle 8 -> err=0.
